// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run controller in front of sequence_ctr and the PA command
// sequence memory. Owns the shadow configuration, the memory write port and
// ctr_en. Optional run abort is enabled by defining SEQ_ABORT_EN.
module seq_run_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLDOFF_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [6:0]        cfg_end_addr,
  input  logic [11:0]       cfg_time_gap,
  input  logic [CNT_W-1:0]  cfg_cmd_count,
  input  logic              mem_wr_req,
  input  logic [6:0]        mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_ack,
  output logic              mem_we,
  output logic [6:0]        mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              start,
  input  logic              abort,
  input  logic              manchester_wren,
  output logic              ctr_en,
  output logic [6:0]        seq_end_addr,
  output logic [11:0]       time_gap,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  cmds_sent
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cmd_count;
  logic [HOLD_W-1:0] hold_cnt;
  logic              abort_flag;
  logic              abort_hit;
  logic              terminal;
  logic              wr_accept;

`ifdef SEQ_ABORT_EN
  assign abort_hit = (state == S_RUN) && abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Last command of the run: either the programmed count or single-shot mode.
  assign terminal = (state == S_RUN) && manchester_wren &&
                    ((cmds_sent == cmd_count - CNT_W'(1)) || (seq_end_addr == 7'd0));

  // Dropped in the terminal cycle itself so sequence_ctr cannot issue one more.
  assign ctr_en = (state == S_RUN) && !terminal;

  assign busy = (state != S_IDLE);

  // Start has priority over a pending write; ack high blocks back-to-back accepts.
  assign wr_accept = (state == S_IDLE) && !start && mem_wr_req && !mem_wr_ack;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RUN;
      S_RUN:     if (terminal || abort_hit) state_nxt = S_HOLDOFF;
      S_HOLDOFF: if (hold_cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Shadow config, write port, command counter, holdoff timer and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_end_addr <= 7'd0;
      time_gap     <= 12'd1;
      cmd_count    <= CNT_W'(1);
      cmds_sent    <= '0;
      hold_cnt     <= '0;
      abort_flag   <= 1'b0;
      mem_we       <= 1'b0;
      mem_wr_ack   <= 1'b0;
      mem_addr     <= 7'd0;
      mem_din      <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_wr_ack <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cfg_err    <= (state != S_IDLE) && (cfg_we || start);

      if ((state == S_IDLE) && cfg_we) begin
        seq_end_addr <= cfg_end_addr;
        time_gap     <= (cfg_time_gap == 12'd0) ? 12'd1 : cfg_time_gap;
        cmd_count    <= (cfg_cmd_count == '0) ? CNT_W'(1) : cfg_cmd_count;
      end

      if (wr_accept) begin
        mem_we     <= 1'b1;
        mem_wr_ack <= 1'b1;
        mem_addr   <= mem_wr_addr;
        mem_din    <= mem_wr_data;
      end

      if ((state == S_IDLE) && start) begin
        cmds_sent  <= '0;
        abort_flag <= 1'b0;
      end

      if ((state == S_RUN) && manchester_wren && (cmds_sent != '1))
        cmds_sent <= cmds_sent + CNT_W'(1);

      if ((state == S_RUN) && (state_nxt == S_HOLDOFF)) begin
        hold_cnt   <= HOLD_W'(HOLDOFF_CYC - 1);
        abort_flag <= abort_hit;
      end

      if (state == S_HOLDOFF) begin
        if (hold_cnt == '0) begin
          done    <= 1'b1;
          aborted <= abort_flag;
        end else begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench for seq_run_ctrl: table-driven configurations, hand
// sequences for write stalling, config errors, abort and reset, plus random runs.
module tb_seq_run_ctrl;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned HOLDOFF_CYC = 8;

`ifdef SEQ_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [6:0]        cfg_end_addr;
  logic [11:0]       cfg_time_gap;
  logic [CNT_W-1:0]  cfg_cmd_count;
  logic              mem_wr_req;
  logic [6:0]        mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic              mem_we;
  logic [6:0]        mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              start;
  logic              abort;
  logic              manchester_wren;
  logic              ctr_en;
  logic [6:0]        seq_end_addr;
  logic [11:0]       time_gap;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              cfg_err;
  logic [CNT_W-1:0]  cmds_sent;

  seq_run_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_end_addr(cfg_end_addr), .cfg_time_gap(cfg_time_gap),
    .cfg_cmd_count(cfg_cmd_count),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .start(start), .abort(abort), .manchester_wren(manchester_wren),
    .ctr_en(ctr_en), .seq_end_addr(seq_end_addr), .time_gap(time_gap),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .cmds_sent(cmds_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [6:0]       e;
    logic [11:0]      g;
    logic [CNT_W-1:0] c;
    logic [11:0]      exp_tg;
    int               exp_n;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [6:0] e, input logic [11:0] g, input logic [CNT_W-1:0] c);
    cfg_end_addr  = e;
    cfg_time_gap  = g;
    cfg_cmd_count = c;
    cfg_we        = 1'b1;
    clk_step();
    cfg_we        = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " busy"},         32'(busy), 32'd0);
    chk({nm, " ctr_en"},       32'(ctr_en), 32'd0);
    chk({nm, " seq_end_addr"}, 32'(seq_end_addr), 32'd0);
    chk({nm, " time_gap"},     32'(time_gap), 32'd1);
    chk({nm, " cmds_sent"},    32'(cmds_sent), 32'd0);
    chk({nm, " done"},         32'(done), 32'd0);
    chk({nm, " aborted"},      32'(aborted), 32'd0);
    chk({nm, " cfg_err"},      32'(cfg_err), 32'd0);
    chk({nm, " mem_we"},       32'(mem_we), 32'd0);
    chk({nm, " mem_wr_ack"},   32'(mem_wr_ack), 32'd0);
    chk({nm, " mem_addr"},     32'(mem_addr), 32'd0);
    chk({nm, " mem_din"},      32'(mem_din), 32'd0);
  endtask

  // Launch a run, act as sequence_ctr (one wren pulse every time_gap enabled
  // clocks), then check pulse count, done latency and status at the end.
  task automatic do_run(input string nm, input int exp_n, input logic [6:0] exp_end,
                        input logic [11:0] exp_tg, input int abort_after,
                        input bit poke, input bit exp_ab);
    int   pulses, term, done_at, acks, errs_cfg, rerise, gcnt;
    logic wr, en, ab_seen;
    bit   ab_sent;
    pulses = 0; term = -1; done_at = -1; acks = 0; errs_cfg = 0; rerise = 0;
    gcnt = 0; wr = 1'b0; en = 1'b0; ab_seen = 1'b0; ab_sent = 1'b0;
    start = 1'b1;
    clk_step();
    start  = 1'b0;
    cfg_we = 1'b0;
    chk({nm, " busy after start"}, 32'(busy), 32'd1);
    chk({nm, " cmds_sent cleared"}, 32'(cmds_sent), 32'd0);
    for (int cyc = 0; cyc < 2000 && done_at < 0; cyc++) begin
      manchester_wren = wr;
      abort = (abort_after > 0) && !ab_sent && (pulses == abort_after) && !wr;
      if (abort) ab_sent = 1'b1;
      if (poke && cyc == 2) begin
        cfg_we = 1'b1; cfg_end_addr = 7'h55; cfg_time_gap = 12'habc; cfg_cmd_count = CNT_W'(99);
      end
      if (poke && cyc == 3) begin cfg_we = 1'b0; start = 1'b1; end
      if (poke && cyc == 4) start = 1'b0;
      #1;
      en = ctr_en;
      if (wr) pulses++;
      if (term < 0 && !en) term = cyc;
      if (term >= 0 && en) rerise++;
      if (mem_wr_ack) acks++;
      if (cfg_err) errs_cfg++;
      if (!en) begin gcnt = 0; wr = 1'b0; end
      else if (gcnt + 1 >= int'(time_gap)) begin wr = 1'b1; gcnt = 0; end
      else begin wr = 1'b0; gcnt++; end
      clk_step();
      if (done) begin done_at = cyc + 1; ab_seen = aborted; end
    end
    manchester_wren = 1'b0;
    abort = 1'b0;
    if (done_at < 0) begin
      chk({nm, " done before timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, " wren pulses"}, 32'(pulses), 32'(exp_n));
      chk({nm, " done latency"}, 32'(done_at - term),
          exp_ab ? 32'(HOLDOFF_CYC) : 32'(HOLDOFF_CYC + 1));
      chk({nm, " cmds_sent"}, 32'(cmds_sent), 32'(exp_n));
      chk({nm, " busy at done"}, 32'(busy), 32'd0);
      chk({nm, " aborted at done"}, 32'(ab_seen), 32'(exp_ab));
      chk({nm, " seq_end_addr"}, 32'(seq_end_addr), 32'(exp_end));
      chk({nm, " time_gap"}, 32'(time_gap), 32'(exp_tg));
      chk({nm, " acks while busy"}, 32'(acks), 32'd0);
      chk({nm, " cfg_err pulses"}, 32'(errs_cfg), poke ? 32'd2 : 32'd0);
      chk({nm, " ctr_en re-rise"}, 32'(rerise), 32'd0);
      clk_step();
      chk({nm, " done one cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcnt;
    logic [6:0]       re;
    logic [11:0]      rg;
    logic [CNT_W-1:0] rc;
    int               rn;
    checks = 0; errors = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_end_addr = '0; cfg_time_gap = '0; cfg_cmd_count = '0;
    mem_wr_req = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    start = 1'b0; abort = 1'b0; manchester_wren = 1'b0;

    // {end, gap, count, expected time_gap, expected pulses}
    tbl[0] = '{7'd3, 12'd4, CNT_W'(6),  12'd4, 6};
    tbl[1] = '{7'd5, 12'd1, CNT_W'(5),  12'd1, 5};
    tbl[2] = '{7'd0, 12'd2, CNT_W'(10), 12'd2, 1};
    tbl[3] = '{7'd7, 12'd0, CNT_W'(0),  12'd1, 1};
    tbl[4] = '{7'd2, 12'd3, CNT_W'(1),  12'd3, 1};
    tbl[5] = '{7'd1, 12'd2, CNT_W'(3),  12'd2, 3};

    clk_step();
    clk_step();
    check_reset_vals("reset");
    rst = 1'b0;
    clk_step();

    for (int i = 0; i < 6; i++) begin
      apply_cfg(tbl[i].e, tbl[i].g, tbl[i].c);
      chk($sformatf("tbl%0d shadow end", i), 32'(seq_end_addr), 32'(tbl[i].e));
      chk($sformatf("tbl%0d shadow gap", i), 32'(time_gap), 32'(tbl[i].exp_tg));
      do_run($sformatf("tbl%0d", i), tbl[i].exp_n, tbl[i].e, tbl[i].exp_tg, 0, 1'b0, 1'b0);
    end

    // Idle writes: one cycle latency, no re-accept while ack is high.
    mem_wr_req = 1'b1; mem_wr_addr = 7'h05; mem_wr_data = 16'hbeef;
    clk_step();
    chk("idle wr ack", 32'(mem_wr_ack), 32'd1);
    chk("idle wr we", 32'(mem_we), 32'd1);
    chk("idle wr addr", 32'(mem_addr), 32'h05);
    chk("idle wr din", 32'(mem_din), 32'hbeef);
    clk_step();
    chk("wr no back-to-back ack", 32'(mem_wr_ack), 32'd0);
    chk("wr no back-to-back we", 32'(mem_we), 32'd0);
    clk_step();
    chk("held req re-accepted", 32'(mem_wr_ack), 32'd1);
    mem_wr_req = 1'b0;
    clk_step();
    chk("wr ack drops", 32'(mem_wr_ack), 32'd0);

    // Start and write request together: run wins, write stalls until idle.
    apply_cfg(7'd2, 12'd2, CNT_W'(3));
    mem_wr_req = 1'b1; mem_wr_addr = 7'h2a; mem_wr_data = 16'h1234;
    do_run("stall", 3, 7'd2, 12'd2, 0, 1'b0, 1'b0);
    chk("stalled wr ack", 32'(mem_wr_ack), 32'd1);
    chk("stalled wr we", 32'(mem_we), 32'd1);
    chk("stalled wr addr", 32'(mem_addr), 32'h2a);
    chk("stalled wr din", 32'(mem_din), 32'h1234);
    mem_wr_req = 1'b0;
    clk_step();
    chk("stalled wr we one cycle", 32'(mem_we), 32'd0);

    // Config write and start while running are rejected with cfg_err.
    apply_cfg(7'd3, 12'd4, CNT_W'(6));
    do_run("poke", 6, 7'd3, 12'd4, 0, 1'b1, 1'b0);

    // Abort after the second command (ignored when the feature is absent).
    apply_cfg(7'd7, 12'd3, CNT_W'(10));
    do_run("abort", ABORT_ON ? 2 : 10, 7'd7, 12'd3, 2, 1'b0, ABORT_ON);

    // Reset in the middle of a run.
    apply_cfg(7'd4, 12'd2, CNT_W'(8));
    start = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    clk_step();
    chk("pre-reset ctr_en", 32'(ctr_en), 32'd1);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    check_reset_vals("midrun reset");
    dcnt = 0;
    for (int k = 0; k < int'(HOLDOFF_CYC) + 4; k++) begin
      clk_step();
      if (done) dcnt++;
    end
    chk("no done after reset", 32'(dcnt), 32'd0);

    // Random configurations, half of them written in the same cycle as start.
    for (int r = 0; r < 20; r++) begin
      re = 7'($urandom_range(0, 7));
      rg = 12'($urandom_range(0, 3));
      rc = CNT_W'($urandom_range(0, 9));
      rn = (re == 7'd0) ? 1 : ((rc == '0) ? 1 : int'(rc));
      cfg_end_addr = re; cfg_time_gap = rg; cfg_cmd_count = rc;
      if ($urandom_range(0, 1) == 0) begin
        cfg_we = 1'b1;
      end else begin
        apply_cfg(re, rg, rc);
      end
      do_run($sformatf("rnd%0d", r), rn, re, (rg == 12'd0) ? 12'd1 : rg, 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
